// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with signs fixed up on the final cycle.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iStart,
    input  logic [2:0]       iFunct3,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    output logic             oBusy,
    output logic             oDone,
    output logic [WIDTH-1:0] oResult
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [2:0]         funct;
    logic               fast, negMain, negRem;
    logic [WIDTH-1:0]   opnd, fastRes;
    logic [2*WIDTH-1:0] acc;

    // Operand decode on the request side
    logic             isDiv, aSigned, bSigned, aNeg, bNeg, divZero, divOvf, fastHit;
    logic [WIDTH-1:0] aMag, bMag, fastVal;

    always_comb begin
        isDiv   = iFunct3[2];
        aSigned = isDiv ? ~iFunct3[0] : ~(iFunct3[1] & iFunct3[0]);
        bSigned = isDiv ? ~iFunct3[0] : ~iFunct3[1];
        aNeg    = aSigned & iA[WIDTH-1];
        bNeg    = bSigned & iB[WIDTH-1];
        aMag    = aNeg ? -iA : iA;
        bMag    = bNeg ? -iB : iB;
        divZero = (iB == '0);
        divOvf  = ~iFunct3[0] && (iA == {1'b1, {(WIDTH-1){1'b0}}}) && (iB == '1);
        fastHit = isDiv & (divZero | divOvf);
        if (divZero) fastVal = iFunct3[1] ? iA : '1;
        else         fastVal = iFunct3[1] ? '0 : iA;
    end

    // One iteration of the datapath, plus sign fix-up of the value it produces
    logic [WIDTH:0]     mulSum, shifted, diff;
    logic [2*WIDTH-1:0] mulNext, divNext, stepNext, prodS;
    logic [WIDTH-1:0]   quotS, remS, finalRes;

    always_comb begin
        mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        mulNext  = {mulSum, acc[WIDTH-1:1]};
        shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff     = shifted - {1'b0, opnd};
        // A borrow means the trial subtraction failed: keep the shifted remainder
        divNext  = diff[WIDTH] ? {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                               : {diff[WIDTH-1:0],    acc[WIDTH-2:0], 1'b1};
        stepNext = funct[2] ? divNext : mulNext;
        prodS    = negMain ? -stepNext : stepNext;
        quotS    = negMain ? -stepNext[WIDTH-1:0] : stepNext[WIDTH-1:0];
        remS     = negRem  ? -stepNext[2*WIDTH-1:WIDTH] : stepNext[2*WIDTH-1:WIDTH];
        case (funct)
            3'b000:          finalRes = prodS[WIDTH-1:0];
            3'b100, 3'b101:  finalRes = quotS;
            3'b110, 3'b111:  finalRes = remS;
            default:         finalRes = prodS[2*WIDTH-1:WIDTH];
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state   <= IDLE;
            cnt     <= '0;
            funct   <= '0;
            fast    <= 1'b0;
            negMain <= 1'b0;
            negRem  <= 1'b0;
            opnd    <= '0;
            fastRes <= '0;
            acc     <= '0;
            oBusy   <= 1'b0;
            oDone   <= 1'b0;
            oResult <= '0;
        end else begin
            oDone <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (iStart) begin
                        funct   <= iFunct3;
                        acc     <= {{WIDTH{1'b0}}, isDiv ? aMag : bMag};
                        opnd    <= isDiv ? bMag : aMag;
                        negMain <= aNeg ^ bNeg;
                        negRem  <= aNeg;
                        fast    <= fastHit;
                        fastRes <= fastVal;
                        cnt     <= '0;
                        state   <= CALC;
                        oBusy   <= 1'b1;
                    end else begin
                        state <= IDLE;
                        oBusy <= 1'b0;
                    end
                end
                CALC: begin
                    if (fast) begin
                        oResult <= fastRes;
                        state   <= DONE;
                        oBusy   <= 1'b0;
                        oDone   <= 1'b1;
                    end else begin
                        acc <= stepNext;
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(WIDTH-1)) begin
                            oResult <= finalRes;
                            state   <= DONE;
                            oBusy   <= 1'b0;
                            oDone   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    oBusy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed and randomized checks of mul_div_unit against a plain-arithmetic RV32M model.
module tb_mul_div_unit;
    logic        iCLK = 1'b0;
    logic        iRST, iStart;
    logic [2:0]  iFunct3;
    logic [31:0] iA, iB;
    logic        oBusy, oDone;
    logic [31:0] oResult;

    int vectors = 0;
    int miscompares = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iFunct3(iFunct3),
        .iA(iA), .iB(iB), .oBusy(oBusy), .oDone(oDone), .oResult(oResult)
    );

    always #5 iCLK = ~iCLK;

    function automatic logic [31:0] refModel(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint x, y, p;
        int sa, sb;
        logic [63:0] pb;
        logic ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        x = {{32{a[31]}}, a};
        y = {{32{b[31]}}, b};
        case (f)
            3'd0, 3'd1: p = x * y;
            3'd2:       p = x * longint'({32'b0, b});
            3'd3:       p = longint'({32'b0, a}) * longint'({32'b0, b});
            default:    p = 0;
        endcase
        pb = p;
        case (f)
            3'd0:    return pb[31:0];
            3'd1, 3'd2, 3'd3: return pb[63:32];
            3'd4:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
            3'd5:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6:    return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge iCLK);
        iFunct3 = f; iA = a; iB = b; iStart = 1'b1;
        @(posedge iCLK); #1;
        iStart = 1'b0;
        chk("busy after accept", 32'(oBusy), 32'd1);
    endtask

    // Counts edges after the accepting edge until oDone; optionally pulses a stray start
    task automatic awaitDone(input string tag, input logic [31:0] exp, input int expLat, input int pulseAt);
        int lat = 0;
        do begin
            @(posedge iCLK); #1;
            lat++;
            iStart = (lat == pulseAt);
            if (iStart) begin
                iA = $urandom; iB = $urandom; iFunct3 = 3'($urandom);
            end
            if (!oDone) chk({tag, " busy"}, 32'(oBusy), 32'd1);
        end while (!oDone && lat < 100);
        iStart = 1'b0;
        chk({tag, " latency"}, lat, expLat);
        chk({tag, " busy at done"}, 32'(oBusy), 32'd0);
        chk({tag, " result"}, oResult, exp);
    endtask

    initial begin
        int seen;
        logic [2:0]  f;
        logic [31:0] a, b, e;
        int lat;

        iRST = 1'b1; iStart = 1'b0; iFunct3 = '0; iA = '0; iB = '0;
        repeat (2) @(posedge iCLK);
        #1;
        chk("reset busy", 32'(oBusy), 32'd0);
        chk("reset done", 32'(oDone), 32'd0);
        chk("reset result", oResult, 32'd0);
        @(negedge iCLK); iRST = 1'b0;

        launch(3'd0, 32'd7, 32'hFFFF_FFFD);
        awaitDone("MUL 7*-3", 32'hFFFF_FFEB, 32, 0);
        @(posedge iCLK); #1;
        chk("done pulse width", 32'(oDone), 32'd0);
        chk("result held", oResult, 32'hFFFF_FFEB);

        launch(3'd1, 32'h8000_0000, 32'h8000_0000); awaitDone("MULH", 32'h4000_0000, 32, 0);
        launch(3'd3, 32'h8000_0000, 32'h8000_0000); awaitDone("MULHU", 32'h4000_0000, 32, 0);
        launch(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF); awaitDone("MULHSU", 32'hFFFF_FFFF, 32, 0);
        launch(3'd4, 32'hFFFF_FFF9, 32'd2);         awaitDone("DIV -7/2", 32'hFFFF_FFFD, 32, 0);
        launch(3'd6, 32'hFFFF_FFF9, 32'd2);         awaitDone("REM -7/2", 32'hFFFF_FFFF, 32, 0);
        launch(3'd5, 32'hFFFF_FFF9, 32'd2);         awaitDone("DIVU", 32'h7FFF_FFFC, 32, 0);

        launch(3'd5, 32'h5555_AAAA, 32'd0);         awaitDone("DIVU by 0", 32'hFFFF_FFFF, 1, 0);
        launch(3'd7, 32'h1234, 32'd0);              awaitDone("REMU by 0", 32'h1234, 1, 0);
        launch(3'd4, 32'h8000_0000, 32'hFFFF_FFFF); awaitDone("DIV ovf", 32'h8000_0000, 1, 0);
        launch(3'd6, 32'h8000_0000, 32'hFFFF_FFFF); awaitDone("REM ovf", 32'h0, 1, 0);

        // Stray start mid-operation must not disturb the running multiply
        launch(3'd0, 32'd1234, 32'd5678);           awaitDone("ignored start", 32'd7006652, 32, 5);

        // Start issued during the DONE cycle: no idle bubble
        iFunct3 = 3'd0; iA = 32'd11; iB = 32'd13; iStart = 1'b1;
        @(posedge iCLK); #1;
        iStart = 1'b0;
        chk("b2b busy", 32'(oBusy), 32'd1);
        chk("b2b no done", 32'(oDone), 32'd0);
        awaitDone("b2b MUL", 32'd143, 32, 0);

        // Reset mid-divide aborts without a done pulse
        launch(3'd4, 32'd1000, 32'd7);
        repeat (9) @(posedge iCLK);
        @(negedge iCLK); iRST = 1'b1;
        @(posedge iCLK); #1;
        iRST = 1'b0;
        chk("abort busy", 32'(oBusy), 32'd0);
        chk("abort done", 32'(oDone), 32'd0);
        chk("abort result", oResult, 32'd0);
        seen = 0;
        repeat (40) begin
            @(posedge iCLK); #1;
            if (oDone) seen++;
        end
        chk("no done after abort", seen, 0);
        launch(3'd0, 32'd3, 32'd5);                 awaitDone("MUL 3*5", 32'd15, 32, 0);

        // Reset wins over a simultaneous start
        @(negedge iCLK);
        iRST = 1'b1; iStart = 1'b1; iFunct3 = 3'd0; iA = 32'd3; iB = 32'd5;
        @(posedge iCLK); #1;
        iRST = 1'b0; iStart = 1'b0;
        chk("rst prio busy", 32'(oBusy), 32'd0);
        @(posedge iCLK); #1;
        chk("rst prio stays idle", 32'(oBusy), 32'd0);

        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom);
            a = pick();
            b = pick();
            e = refModel(f, a, b);
            lat = (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 32;
            launch(f, a, b);
            awaitDone($sformatf("rand f=%0d a=%0h b=%0h", f, a, b), e, lat, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
